btn_input_ctrl: RTL and testbench
=================================

# btn_input_ctrl

Front-end input stage between the raw board buttons (`left`, `right`, `jump`) and the game core inside `top_debug`. It synchronises and debounces each button, produces clean levels and one-cycle press pulses, and runs a jump-charge state machine. The machine turns a hold-and-release of `jump` into a single `jump_fire` event that carries a charge magnitude and a direction. The game physics consume only these outputs, never raw pins.

## Interface
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles before a debounced level changes (10 ms at 100 MHz).
- `CHARGE_TICK`, 2_000_000: cycles per charge increment.
- `CHARGE_MAX`, 31: saturation value of the charge.
- `CHARGE_W`, 5: width of the charge output; must hold `CHARGE_MAX`.

- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: game active; when low, the FSM is forced to IDLE and no pulses or fire events are produced.
- `left`, `right`, `jump` in 1 each: raw asynchronous button inputs.
- `left_lvl`, `right_lvl`, `jump_lvl` out 1 each: debounced levels.
- `left_pulse`, `right_pulse` out 1 each: one-cycle rising-edge pulses of the debounced levels.
- `charging` out 1: high while the FSM is in CHARGE.
- `jump_fire` out 1: one-cycle jump event.
- `jump_charge` out CHARGE_W: charge captured at fire; holds its value until the next fire.
- `jump_dir` out 2: direction captured at fire. 00 = none, 01 = left, 10 = right.

## Operation
- Per button: a 2-flop synchroniser feeds a debouncer.
  - The debouncer counter clears whenever the synchronised input equals the current level.
  - Otherwise the counter increments.
  - When the count reaches DEB_CYCLES-1, the level toggles and the counter clears.
- Pulses: `x_pulse` = `x_lvl` & ~`x_lvl_d`, registered. Pulses are gated by `enable`.
- FSM states: IDLE, CHARGE, FIRE, WAIT_REL.
  - IDLE → CHARGE: on `jump_lvl` rising with `enable`=1. Charge and tick counter are cleared.
  - CHARGE: the tick counter counts to CHARGE_TICK-1, then the charge increments, saturating at CHARGE_MAX.
  - CHARGE → FIRE: when `jump_lvl`=0.
  - FIRE (one cycle):
    - `jump_fire`=1 and `jump_charge` = current charge.
    - `jump_dir` = {`right_lvl`, `left_lvl`}, except that both set gives 00.
    - Next state is IDLE.
  - WAIT_REL: used only with JUMP_AUTOFIRE_EN. Exits to IDLE when `jump_lvl`=0.
- Release with charge 0 still fires, with `jump_charge`=0.
- `enable` falling in any state: next state is IDLE with no fire, and the charge clears. `jump` already held when `enable` rises does not start charging; a new rising edge is required.
- Reset values: all levels, pulses, `charging`, `jump_fire` = 0; `jump_charge` = 0; `jump_dir` = 00; state IDLE; all counters 0. Reset mid-charge discards the charge without firing.

## Timing
- Raw edge at cycle 0 → `x_lvl` changes at cycle 2+DEB_CYCLES. Glitches shorter than DEB_CYCLES never propagate.
- `x_pulse` is asserted in the cycle after `x_lvl` rises, for exactly 1 cycle.
- `charging` rises 1 cycle after `jump_lvl` rises.
- The charge increments every CHARGE_TICK cycles while in CHARGE: value k after k·CHARGE_TICK cycles, up to CHARGE_MAX.
- `jump_fire` is asserted 1 cycle after `jump_lvl` falls. `jump_charge` and `jump_dir` update in the same cycle.
- Simultaneous `jump_lvl` fall and tick expiry: the increment is applied first, and the fire carries the incremented value.

## Configuration
- `JUMP_AUTOFIRE_EN` defined:
  - The cycle the charge reaches CHARGE_MAX, CHARGE → FIRE with charge = CHARGE_MAX.
  - FIRE → WAIT_REL.
  - A new charge requires release and a fresh press.
- Undefined: the charge saturates and holds in CHARGE until release. WAIT_REL is unreachable and may be omitted.

## Structure
- Package `btn_pkg`: FSM state enum, `jump_dir` encodings (DIR_NONE, DIR_LEFT, DIR_RIGHT).
- Sub-module `btn_debounce`: synchroniser, debounce counter, level output; instantiated 3×.
- The FSM, pulse logic and capture registers live in `btn_input_ctrl`.

## Test plan
Bench parameters: DEB_CYCLES=4, CHARGE_TICK=3, CHARGE_MAX=7.
- Bounce: `left` toggles every 2 cycles for 20 cycles, then holds 1 → `left_lvl` rises once, 6 cycles after the final edge; exactly one `left_pulse`.
- Short jump: hold `jump` 10 debounced cycles with `right`=1 → `jump_fire` for one cycle, `jump_charge`=3, `jump_dir`=10.
- Long hold without the macro: hold `jump` 40 cycles → `jump_charge`=7 on release; no fire before release.
- Long hold with `JUMP_AUTOFIRE_EN`: hold `jump` → fire at the cycle after the charge reaches 7; no second fire until release and re-press.
- Both directions held at fire → `jump_dir`=00. Release with charge 0 → fire with `jump_charge`=0.
- `enable` dropped mid-charge, or `sys_rst_n`=0 mid-charge → no `jump_fire`, `charging`=0 next cycle; reset also clears `jump_charge` to 0.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the button input front-end.
//   - jump FSM state encoding
//   - jump_dir encodings (DIR_NONE / DIR_LEFT / DIR_RIGHT)
//   - button index map into the packed debouncer bus
//   - dir_encode(): direction from the two debounced side levels
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHARGE   = 2'd1,
    ST_FIRE     = 2'd2,
    ST_WAIT_REL = 2'd3
  } jump_state_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  // Bit positions of each button on the packed raw/level buses.
  localparam int NUM_BTN   = 3;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_JUMP  = 2;

  // Both sides held cancel out to "no direction".
  function automatic logic [1:0] dir_encode(input logic left_lvl, input logic right_lvl);
    logic [1:0] dir;
    case ({right_lvl, left_lvl})
      2'b01:   dir = DIR_LEFT;
      2'b10:   dir = DIR_RIGHT;
      default: dir = DIR_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel.
//   2-flop synchroniser followed by a stability counter. The level only
//   toggles after the synchronised input has disagreed with it for
//   DEB_CYCLES consecutive cycles; any agreement clears the counter, so
//   shorter glitches never reach the level.
// Ports:
//   sys_clk    in  system clock
//   sys_rst_n  in  synchronous active-low reset
//   raw_i      in  raw asynchronous button pin
//   lvl_o      out debounced level
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic raw_i,
  output logic lvl_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (sync_q[1] == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      lvl_d = ~lvl_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl_o = lvl_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// btn_input_ctrl: input front-end between the board buttons and the game core.
//   Debounces left/right/jump, emits rising-edge press pulses for left/right
//   and turns a hold-and-release of jump into a single jump_fire event
//   carrying a charge magnitude and a direction.
// Optional feature: define JUMP_AUTOFIRE_EN to fire automatically the cycle
//   the charge saturates; the FSM then waits for release before re-arming.
// Ports:
//   sys_clk, sys_rst_n           clock, synchronous active-low reset
//   enable                       game active; low forces IDLE, gates pulses/fire
//   left, right, jump            raw button pins
//   left_lvl/right_lvl/jump_lvl  debounced levels
//   left_pulse, right_pulse      one-cycle press pulses
//   charging                     FSM is in CHARGE
//   jump_fire                    one-cycle jump event
//   jump_charge                  charge captured at fire (held until next fire)
//   jump_dir                     direction captured at fire
module btn_input_ctrl
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int CHARGE_TICK = 2_000_000,
  parameter int CHARGE_MAX  = 31,
  parameter int CHARGE_W    = 5
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                enable,
  input  logic                left,
  input  logic                right,
  input  logic                jump,
  output logic                left_lvl,
  output logic                right_lvl,
  output logic                jump_lvl,
  output logic                left_pulse,
  output logic                right_pulse,
  output logic                charging,
  output logic                jump_fire,
  output logic [CHARGE_W-1:0] jump_charge,
  output logic [1:0]          jump_dir
);

  localparam int TICK_W = (CHARGE_TICK > 1) ? $clog2(CHARGE_TICK) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(CHARGE_TICK - 1);
  localparam logic [CHARGE_W-1:0] CHG_MAX   = CHARGE_W'(CHARGE_MAX);

  // ---------------------------------------------------------------- debounce
  logic [NUM_BTN-1:0] raw, lvl, lvl_prev_q, rise;

  assign raw = {jump, right, left};

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .raw_i     (raw),
    .lvl_o     (lvl)
  );

  // lvl_prev_q tracks regardless of enable, so a button already held when
  // enable rises never looks like a fresh press.
  assign rise = lvl & ~lvl_prev_q;

  logic [1:0] pulse_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lvl_prev_q <= '0;
      pulse_q    <= '0;
    end else begin
      lvl_prev_q <= lvl;
      pulse_q    <= enable ? rise[BTN_RIGHT:BTN_LEFT] : 2'b00;
    end
  end

  // --------------------------------------------------------------- jump FSM
  jump_state_e          state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [CHARGE_W-1:0]  charge_q, charge_d;
  logic [CHARGE_W-1:0]  jump_charge_q;
  logic [1:0]           jump_dir_q;
  logic                 fire_take;

  // Charge datapath. Computed before the state decision so that a release
  // coinciding with tick expiry fires with the incremented value.
  always_comb begin
    tick_d   = '0;
    charge_d = '0;
    if (enable && state_q == ST_CHARGE) begin
      if (tick_q == TICK_LAST) begin
        tick_d   = '0;
        charge_d = (charge_q == CHG_MAX) ? charge_q : charge_q + CHARGE_W'(1);
      end else begin
        tick_d   = tick_q + TICK_W'(1);
        charge_d = charge_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (rise[BTN_JUMP]) state_d = ST_CHARGE;
`ifdef JUMP_AUTOFIRE_EN
        ST_CHARGE: if (!lvl[BTN_JUMP] || charge_d == CHG_MAX) state_d = ST_FIRE;
        ST_FIRE:   state_d = ST_WAIT_REL;
        ST_WAIT_REL: if (!lvl[BTN_JUMP]) state_d = ST_IDLE;
`else
        ST_CHARGE: if (!lvl[BTN_JUMP]) state_d = ST_FIRE;
        ST_FIRE:   state_d = ST_IDLE;
`endif
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Capture on the CHARGE->FIRE transition so the held outputs are already
  // valid in the cycle jump_fire is high.
  assign fire_take = (state_q == ST_CHARGE) && (state_d == ST_FIRE);

  // State register and capture registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      tick_q        <= '0;
      charge_q      <= '0;
      jump_charge_q <= '0;
      jump_dir_q    <= DIR_NONE;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      charge_q <= charge_d;
      if (fire_take) begin
        jump_charge_q <= charge_d;
        jump_dir_q    <= dir_encode(lvl[BTN_LEFT], lvl[BTN_RIGHT]);
      end
    end
  end

  // Output decode.
  always_comb begin
    charging  = (state_q == ST_CHARGE);
    jump_fire = (state_q == ST_FIRE) && enable;
  end

  assign left_lvl    = lvl[BTN_LEFT];
  assign right_lvl   = lvl[BTN_RIGHT];
  assign jump_lvl    = lvl[BTN_JUMP];
  assign left_pulse  = pulse_q[0];
  assign right_pulse = pulse_q[1];
  assign jump_charge = jump_charge_q;
  assign jump_dir    = jump_dir_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Bench for btn_input_ctrl. Two instances share all inputs: the main one
// (CHARGE_TICK=3) and a slow-tick one (CHARGE_TICK=16) that makes a
// zero-charge fire reachable through the debouncer.
module tb_btn_input_ctrl;

  localparam int DEB   = 4;
  localparam int TICK  = 3;
  localparam int TICK2 = 16;
  localparam int CMAX  = 7;
  localparam int CW    = 5;

  logic sys_clk, sys_rst_n, enable, left, right, jump;
  logic left_lvl, right_lvl, jump_lvl, left_pulse, right_pulse, charging, jump_fire;
  logic [CW-1:0] jump_charge;
  logic [1:0]    jump_dir;
  logic d2_left_lvl, d2_right_lvl, d2_jump_lvl, d2_left_pulse, d2_right_pulse;
  logic d2_charging, d2_jump_fire;
  logic [CW-1:0] d2_jump_charge;
  logic [1:0]    d2_jump_dir;

  btn_input_ctrl #(.DEB_CYCLES(DEB), .CHARGE_TICK(TICK), .CHARGE_MAX(CMAX), .CHARGE_W(CW)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .left(left), .right(right), .jump(jump),
    .left_lvl(left_lvl), .right_lvl(right_lvl), .jump_lvl(jump_lvl),
    .left_pulse(left_pulse), .right_pulse(right_pulse),
    .charging(charging), .jump_fire(jump_fire),
    .jump_charge(jump_charge), .jump_dir(jump_dir)
  );

  btn_input_ctrl #(.DEB_CYCLES(DEB), .CHARGE_TICK(TICK2), .CHARGE_MAX(CMAX), .CHARGE_W(CW)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .left(left), .right(right), .jump(jump),
    .left_lvl(d2_left_lvl), .right_lvl(d2_right_lvl), .jump_lvl(d2_jump_lvl),
    .left_pulse(d2_left_pulse), .right_pulse(d2_right_pulse),
    .charging(d2_charging), .jump_fire(d2_jump_fire),
    .jump_charge(d2_jump_charge), .jump_dir(d2_jump_dir)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event recorder (negedge, away from the active edge).
  int fire_cnt = 0, last_fire_cyc = -1, fire2_cnt = 0;
  logic [CW-1:0] last_fire_chg = '0, last_fire2_chg = '0;
  logic [1:0]    last_fire_dir = '0, last_fire2_dir = '0;
  int lp_cnt = 0, lp_cyc = -1, lrise_cnt = 0, lrise_cyc = -1;
  int jrise_cyc = -1, jfall_cyc = -1, chg_rise_cyc = -1;
  logic jl_prev = 1'b0, ll_prev = 1'b0, ch_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (jump_fire === 1'b1) begin
      fire_cnt      <= fire_cnt + 1;
      last_fire_cyc <= cyc;
      last_fire_chg <= jump_charge;
      last_fire_dir <= jump_dir;
    end
    if (d2_jump_fire === 1'b1) begin
      fire2_cnt      <= fire2_cnt + 1;
      last_fire2_chg <= d2_jump_charge;
      last_fire2_dir <= d2_jump_dir;
    end
    if (left_pulse === 1'b1) begin
      lp_cnt <= lp_cnt + 1;
      lp_cyc <= cyc;
    end
    if (left_lvl === 1'b1 && ll_prev !== 1'b1) begin
      lrise_cnt <= lrise_cnt + 1;
      lrise_cyc <= cyc;
    end
    if (jump_lvl === 1'b1 && jl_prev !== 1'b1) jrise_cyc <= cyc;
    if (jump_lvl === 1'b0 && jl_prev === 1'b1) jfall_cyc <= cyc;
    if (charging === 1'b1 && ch_prev !== 1'b1) chg_rise_cyc <= cyc;
    jl_prev <= jump_lvl;
    ll_prev <= left_lvl;
    ch_prev <= charging;
  end

  // Reference rules: the debounced jump level stays high exactly as many
  // cycles as the raw pin, and the charge is one step per TICK cycles of
  // that hold, saturating at CMAX.
  function automatic int exp_chg(input int h, input int t);
    int r;
    r = h / t;
    if (r > CMAX) r = CMAX;
    return r;
  endfunction

  function automatic logic [1:0] exp_dir(input logic l, input logic r);
    if (l && r) return 2'b00;
    return {r, l};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Raw jump press of h cycles with the given side buttons held.
  task automatic press(input int h, input logic l, input logic r, output int c);
    left  = l;
    right = r;
    tick(10);
    c    = cyc;
    jump = 1'b1;
    tick(h);
    jump = 1'b0;
    tick(14);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; enable = 1'b1; left = 0; right = 0; jump = 0;
    tick(3);
    n_vec++;
    if ({left_lvl, right_lvl, jump_lvl, left_pulse, right_pulse, charging, jump_fire} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000000",
               {left_lvl, right_lvl, jump_lvl, left_pulse, right_pulse, charging, jump_fire});
    end
    n_vec++;
    if (jump_charge !== '0) begin n_err++; $display("FAIL reset_charge: got %0d want 0", jump_charge); end
    n_vec++;
    if (jump_dir !== 2'b00) begin n_err++; $display("FAIL reset_dir: got %b want 00", jump_dir); end
    n_vec++;
    if ({d2_left_lvl, d2_right_lvl, d2_jump_lvl, d2_left_pulse, d2_right_pulse, d2_charging,
         d2_jump_fire, d2_jump_charge, d2_jump_dir} !== '0) begin
      n_err++;
      $display("FAIL reset_dut2: got %b want 0",
               {d2_left_lvl, d2_right_lvl, d2_jump_lvl, d2_left_pulse, d2_right_pulse,
                d2_charging, d2_jump_fire, d2_jump_charge, d2_jump_dir});
    end
    sys_rst_n = 1'b1;
    tick(8);
    n_vec++;
    if ({left_lvl, jump_lvl, charging, jump_fire} !== 4'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b want 0000", {left_lvl, jump_lvl, charging, jump_fire});
    end
  endtask

  task automatic test_bounce();
    int lr0, lp0, e;
    lr0 = lrise_cnt;
    lp0 = lp_cnt;
    for (int i = 0; i < 10; i++) begin
      left = ~left;
      tick(2);
    end
    left = 1'b1;
    e = cyc;
    tick(12);
    n_vec++;
    if (lrise_cnt - lr0 != 1) begin n_err++; $display("FAIL bounce_rises: got %0d want 1", lrise_cnt - lr0); end
    n_vec++;
    if (lrise_cyc - e != 2 + DEB) begin n_err++; $display("FAIL bounce_latency: got %0d want %0d", lrise_cyc - e, 2 + DEB); end
    n_vec++;
    if (lp_cnt - lp0 != 1) begin n_err++; $display("FAIL bounce_pulses: got %0d want 1", lp_cnt - lp0); end
    n_vec++;
    if (lp_cyc != lrise_cyc + 1) begin n_err++; $display("FAIL pulse_timing: got %0d want %0d", lp_cyc, lrise_cyc + 1); end
    left = 1'b0;
    tick(10);
  endtask

  task automatic test_short_jump();
    int f0, c;
    f0 = fire_cnt;
    press(10, 1'b0, 1'b1, c);
    n_vec++;
    if (fire_cnt - f0 != 1) begin n_err++; $display("FAIL short_fires: got %0d want 1", fire_cnt - f0); end
    n_vec++;
    if (last_fire_chg !== CW'(exp_chg(10, TICK))) begin n_err++; $display("FAIL short_charge: got %0d want %0d", last_fire_chg, exp_chg(10, TICK)); end
    n_vec++;
    if (last_fire_dir !== 2'b10) begin n_err++; $display("FAIL short_dir: got %b want 10", last_fire_dir); end
    n_vec++;
    if (jrise_cyc != c + 2 + DEB) begin n_err++; $display("FAIL jlvl_latency: got %0d want %0d", jrise_cyc, c + 2 + DEB); end
    n_vec++;
    if (chg_rise_cyc != jrise_cyc + 1) begin n_err++; $display("FAIL charging_timing: got %0d want %0d", chg_rise_cyc, jrise_cyc + 1); end
    n_vec++;
    if (last_fire_cyc != jfall_cyc + 1) begin n_err++; $display("FAIL fire_timing: got %0d want %0d", last_fire_cyc, jfall_cyc + 1); end
    n_vec++;
    if (jump_charge !== CW'(3)) begin n_err++; $display("FAIL charge_hold: got %0d want 3", jump_charge); end
  endtask

  task automatic test_long_hold();
    int f0, c;
    f0 = fire_cnt;
    press(40, 1'b1, 1'b0, c);
    n_vec++;
    if (fire_cnt - f0 != 1) begin n_err++; $display("FAIL long_fires: got %0d want 1", fire_cnt - f0); end
    n_vec++;
    if (last_fire_chg !== CW'(CMAX)) begin n_err++; $display("FAIL long_charge: got %0d want %0d", last_fire_chg, CMAX); end
    n_vec++;
    if (last_fire_dir !== 2'b01) begin n_err++; $display("FAIL long_dir: got %b want 01", last_fire_dir); end
`ifdef JUMP_AUTOFIRE_EN
    n_vec++;
    if (last_fire_cyc != jrise_cyc + 1 + CMAX * TICK) begin
      n_err++; $display("FAIL autofire_timing: got %0d want %0d", last_fire_cyc, jrise_cyc + 1 + CMAX * TICK);
    end
`else
    n_vec++;
    if (last_fire_cyc != jfall_cyc + 1) begin n_err++; $display("FAIL long_fire_timing: got %0d want %0d", last_fire_cyc, jfall_cyc + 1); end
`endif
  endtask

  task automatic test_both_dirs();
    int f0, c;
    f0 = fire_cnt;
    press(12, 1'b1, 1'b1, c);
    n_vec++;
    if (fire_cnt - f0 != 1) begin n_err++; $display("FAIL both_fires: got %0d want 1", fire_cnt - f0); end
    n_vec++;
    if (last_fire_dir !== 2'b00) begin n_err++; $display("FAIL both_dir: got %b want 00", last_fire_dir); end
    n_vec++;
    if (last_fire_chg !== CW'(4)) begin n_err++; $display("FAIL both_charge: got %0d want 4", last_fire_chg); end
  endtask

  task automatic test_zero_charge();
    int f0, c;
    f0 = fire2_cnt;
    press(5, 1'b0, 1'b1, c);
    n_vec++;
    if (fire2_cnt - f0 != 1) begin n_err++; $display("FAIL zero_fires: got %0d want 1", fire2_cnt - f0); end
    n_vec++;
    if (last_fire2_chg !== '0) begin n_err++; $display("FAIL zero_charge: got %0d want 0", last_fire2_chg); end
    n_vec++;
    if (last_fire2_dir !== 2'b10) begin n_err++; $display("FAIL zero_dir: got %b want 10", last_fire2_dir); end
    n_vec++;
    if (last_fire_chg !== CW'(exp_chg(5, TICK))) begin n_err++; $display("FAIL min_charge: got %0d want %0d", last_fire_chg, exp_chg(5, TICK)); end
  endtask

  task automatic test_enable_drop();
    int f0, lp0;
    f0 = fire_cnt;
    left = 1'b0; right = 1'b0;
    tick(10);
    jump = 1'b1;
    tick(12);
    n_vec++;
    if (charging !== 1'b1) begin n_err++; $display("FAIL en_precharge: got %b want 1", charging); end
    enable = 1'b0;
    left   = 1'b1;
    lp0    = lp_cnt;
    tick(1);
    n_vec++;
    if (charging !== 1'b0) begin n_err++; $display("FAIL en_drop_charging: got %b want 0", charging); end
    tick(10);
    n_vec++;
    if (lp_cnt != lp0) begin n_err++; $display("FAIL en_pulse_gated: got %0d want %0d", lp_cnt, lp0); end
    n_vec++;
    if (left_lvl !== 1'b1) begin n_err++; $display("FAIL en_lvl_tracks: got %b want 1", left_lvl); end
    enable = 1'b1;
    tick(10);
    n_vec++;
    if (charging !== 1'b0) begin n_err++; $display("FAIL en_held_no_charge: got %b want 0", charging); end
    jump = 1'b0;
    left = 1'b0;
    tick(14);
    n_vec++;
    if (fire_cnt != f0) begin n_err++; $display("FAIL en_no_fire: got %0d want %0d", fire_cnt, f0); end
  endtask

  task automatic test_reset_mid_charge();
    int f0;
    n_vec++;
    if (jump_charge !== CW'(exp_chg(5, TICK))) begin n_err++; $display("FAIL pre_reset_charge: got %0d want %0d", jump_charge, exp_chg(5, TICK)); end
    f0 = fire_cnt;
    left = 1'b1;
    tick(10);
    jump = 1'b1;
    tick(15);
    n_vec++;
    if (charging !== 1'b1) begin n_err++; $display("FAIL rst_precharge: got %b want 1", charging); end
    sys_rst_n = 1'b0;
    jump      = 1'b0;
    tick(1);
    n_vec++;
    if ({charging, jump_fire, jump_dir} !== 4'b0) begin n_err++; $display("FAIL rst_mid_flags: got %b want 0000", {charging, jump_fire, jump_dir}); end
    n_vec++;
    if (jump_charge !== '0) begin n_err++; $display("FAIL rst_mid_charge: got %0d want 0", jump_charge); end
    tick(1);
    sys_rst_n = 1'b1;
    tick(14);
    n_vec++;
    if (fire_cnt != f0) begin n_err++; $display("FAIL rst_no_fire: got %0d want %0d", fire_cnt, f0); end
    left = 1'b0;
    tick(10);
  endtask

  task automatic test_random();
    int f0, g0, c, h;
    logic l, r;
    for (int i = 0; i < 10; i++) begin
      h  = int'($urandom_range(5, 45));
      l  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      f0 = fire_cnt;
      g0 = fire2_cnt;
      press(h, l, r, c);
      n_vec++;
      if (fire_cnt - f0 != 1) begin n_err++; $display("FAIL rnd%0d_fires: h=%0d got %0d want 1", i, h, fire_cnt - f0); end
      n_vec++;
      if (last_fire_chg !== CW'(exp_chg(h, TICK))) begin n_err++; $display("FAIL rnd%0d_charge: h=%0d got %0d want %0d", i, h, last_fire_chg, exp_chg(h, TICK)); end
      n_vec++;
      if (last_fire_dir !== exp_dir(l, r)) begin n_err++; $display("FAIL rnd%0d_dir: got %b want %b", i, last_fire_dir, exp_dir(l, r)); end
      n_vec++;
      if (fire2_cnt - g0 != 1 || last_fire2_chg !== CW'(exp_chg(h, TICK2))) begin
        n_err++; $display("FAIL rnd%0d_slow: h=%0d fires %0d charge %0d want 1 and %0d", i, h, fire2_cnt - g0, last_fire2_chg, exp_chg(h, TICK2));
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0; enable = 1'b1; left = 1'b0; right = 1'b0; jump = 1'b0;
    test_reset();
    test_bounce();
    test_short_jump();
    test_long_hold();
    test_both_dirs();
    test_zero_charge();
    test_enable_drop();
    test_reset_mid_charge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
